// File: rtl/fdivider_ctrl_if.sv
// Configuration handshake bundle for the frequency divider front end.
//   cfg_valid : source offers a new divide ratio on cfg_div
//   cfg_div   : requested divide ratio (DIV_W bits)
//   cfg_ready : sink can accept the ratio this cycle
// master = ratio source, slave = fdivider_ctrl.
interface fdivider_ctrl_if #(
  parameter int DIV_W = 16
);
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready
  );
endinterface

// File: rtl/fdivider_ctrl.sv
// Run-control and configuration front end for the frequency divider.
// Holds a programmable divide ratio (loaded over the cfg handshake while idle)
// and sequences the phase counter with a start/pause/stop state machine.
// Ports:
//   clk_in     : system clock, all logic on the rising edge
//   rst        : synchronous reset, active-high
//   cfg        : ratio handshake (cfg_valid/cfg_div in, cfg_ready out)
//   start      : IDLE->RUN, PAUSE->RUN
//   pause      : RUN->PAUSE
//   stop       : RUN/PAUSE->IDLE (highest priority)
//   tick       : one-cycle pulse at the end of each divided period
//   clk_out    : registered divided clock, low half then high half
//   running    : state is RUN
//   paused     : state is PAUSE
//   tick_count : ticks since the last start from IDLE, saturating
module fdivider_ctrl #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 100,
  parameter int CNT_W       = 8
) (
  input  logic                clk_in,
  input  logic                rst,
  fdivider_ctrl_if.slave      cfg,
  input  logic                start,
  input  logic                pause,
  input  logic                stop,
  output logic                tick,
  output logic                clk_out,
  output logic                running,
  output logic                paused,
  output logic [CNT_W-1:0]    tick_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  logic [1:0]       state;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_last;
  logic [DIV_W-1:0] div_half;
  logic [DIV_W-1:0] cfg_clamped;
  logic             at_end;

  // Ratios of 0 and 1 cannot produce a period with both a low and high half.
  always_comb begin
    cfg_clamped = cfg.cfg_div;
    if (cfg.cfg_div < DIV_W'(2)) begin
      cfg_clamped = DIV_W'(2);
    end
  end

  assign div_last = div_reg - DIV_W'(1);
  assign div_half = div_reg >> 1;
  assign at_end   = (cnt == div_last);

  assign cfg.cfg_ready = (state == ST_IDLE);
  assign running       = (state == ST_RUN);
  assign paused        = (state == ST_PAUSE);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= ST_IDLE;
      div_reg    <= DIV_W'(DEFAULT_DIV);
      cnt        <= '0;
      tick       <= 1'b0;
      clk_out    <= 1'b0;
      tick_count <= '0;
    end else begin
      tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A ratio arriving on the start edge is already in div_reg for the
          // first counting edge, so the new run uses it.
          if (cfg.cfg_valid) begin
            div_reg <= cfg_clamped;
          end
          // The start edge only arms the counter; counting begins next edge.
          if (start) begin
            state      <= ST_RUN;
            cnt        <= '0;
            tick_count <= '0;
          end
        end

        ST_RUN: begin
          if (stop) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            clk_out <= 1'b0;
          end else if (pause) begin
            // cnt, clk_out and tick_count hold; tick already cleared above.
            state <= ST_PAUSE;
          end else begin
            // Phase decision uses the pre-edge count: low for floor(div/2)
            // cycles, then high for the remainder.
            clk_out <= (cnt >= div_half);
            if (at_end) begin
              cnt  <= '0;
              tick <= 1'b1;
              if (tick_count != '1) begin
                tick_count <= tick_count + CNT_W'(1);
              end
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end
        end

        ST_PAUSE: begin
          if (stop) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            clk_out <= 1'b0;
          end else if (start) begin
            // Resume from the frozen phase; the resume edge does not count.
            state <= ST_RUN;
          end
        end

        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          clk_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fdivider_ctrl.sv
// Self-checking bench for fdivider_ctrl (CNT_W=3 so saturation is reachable).
// Expected ticks (edge number and tick_count) are queued when a run is started
// or resumed and popped by a monitor whenever tick is seen high.
module tb_fdivider_ctrl;
  localparam int DIV_W = 16;
  localparam int CNT_W = 3;

  typedef struct {
    int unsigned at;
    int unsigned count;
  } exp_t;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             start;
  logic             pause;
  logic             stop;
  logic             tick;
  logic             clk_out;
  logic             running;
  logic             paused;
  logic [CNT_W-1:0] tick_count;

  int unsigned cyc = 0;
  int          ntests = 0;
  int          nfail = 0;
  exp_t        exp_q[$];
  exp_t        e;

  fdivider_ctrl_if #(.DIV_W(DIV_W)) cfg_if ();

  fdivider_ctrl #(
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(100),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .cfg       (cfg_if),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .tick      (tick),
    .clk_out   (clk_out),
    .running   (running),
    .paused    (paused),
    .tick_count(tick_count)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Scoreboard: every tick must match the head of the expectation queue.
  always @(negedge clk_in) begin
    if (tick === 1'b1) begin
      ntests++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_tick: tick=1 at edge %0d, required no tick", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e.at || int'(tick_count) !== int'(e.count)) begin
          nfail++;
          $display("FAIL tick_sb: tick at edge %0d count %0d, required edge %0d count %0d",
                   cyc, tick_count, e.at, e.count);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_div = '0;
    repeat (3) step();
    rst = 1'b0;
    ntests++;
    if ({tick, clk_out, running, paused, cfg_if.cfg_ready} !== 5'b00001 || tick_count !== 3'd0) begin
      nfail++;
      $display("FAIL reset_state: tick/clk_out/running/paused/ready=%b count=%0d, required 00001 count 0",
               {tick, clk_out, running, paused, cfg_if.cfg_ready}, tick_count);
    end
  endtask

  task automatic test_default_ratio();
    int unsigned s;
    s = cyc + 1;
    for (int k = 1; k <= 3; k++) exp_q.push_back('{s + 100 * k, k});
    start = 1'b1;
    step();
    start = 1'b0;
    ntests++;
    if ({running, cfg_if.cfg_ready, clk_out} !== 3'b100) begin
      nfail++;
      $display("FAIL default_start: running/ready/clk_out=%b, required 100",
               {running, cfg_if.cfg_ready, clk_out});
    end
    for (int k = 2; k <= 310; k++) begin
      step();
      ntests++;
      if (clk_out !== (((k - 2) % 100) >= 50)) begin
        nfail++;
        $display("FAIL default_clk_out: edge %0d got %b, required %b", k, clk_out, ((k - 2) % 100) >= 50);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    ntests++;
    if ({running, paused, clk_out, tick} !== 4'b0000 || tick_count !== 3'd3 || exp_q.size() != 0) begin
      nfail++;
      $display("FAIL default_stop: run/pause/clk/tick=%b count=%0d pending=%0d, required 0000 count 3 pending 0",
               {running, paused, clk_out, tick}, tick_count, exp_q.size());
    end
  endtask

  task automatic test_cfg_same_edge();
    int unsigned s;
    ntests++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      nfail++;
      $display("FAIL idle_ready: got %b, required 1", cfg_if.cfg_ready);
    end
    s = cyc + 1;
    for (int k = 1; k <= 4; k++) exp_q.push_back('{s + 7 * k, k});
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 16'd7; start = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0; start = 1'b0;
    ntests++;
    if (cfg_if.cfg_ready !== 1'b0 || tick_count !== 3'd0) begin
      nfail++;
      $display("FAIL cfg7_start: ready=%b count=%0d, required ready 0 count 0", cfg_if.cfg_ready, tick_count);
    end
    for (int k = 2; k <= 30; k++) begin
      step();
      // Offer a new ratio mid-run; it must wait until IDLE.
      if (k == 20) begin
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 16'd0;
      end
      ntests++;
      if (clk_out !== (((k - 2) % 7) >= 3)) begin
        nfail++;
        $display("FAIL cfg7_clk_out: edge %0d got %b, required %b", k, clk_out, ((k - 2) % 7) >= 3);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    ntests++;
    if (running !== 1'b0 || tick_count !== 3'd4 || exp_q.size() != 0) begin
      nfail++;
      $display("FAIL cfg7_stop: running=%b count=%0d pending=%0d, required 0 count 4 pending 0",
               running, tick_count, exp_q.size());
    end
  endtask

  task automatic test_clamp();
    int unsigned s;
    // cfg_valid with cfg_div=0 has been held since the previous run.
    step();
    cfg_if.cfg_valid = 1'b0;
    s = cyc + 1;
    for (int k = 1; k <= 5; k++) exp_q.push_back('{s + 2 * k, k});
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      step();
      ntests++;
      if (clk_out !== (((k - 2) % 2) >= 1)) begin
        nfail++;
        $display("FAIL clamp_clk_out: edge %0d got %b, required %b", k, clk_out, ((k - 2) % 2) >= 1);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    ntests++;
    if (tick_count !== 3'd5 || exp_q.size() != 0) begin
      nfail++;
      $display("FAIL clamp_stop: count=%0d pending=%0d, required count 5 pending 0", tick_count, exp_q.size());
    end
  endtask

  task automatic test_pause_resume();
    int unsigned r;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 16'd10;
    step();
    cfg_if.cfg_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    // Edge 6: pre-edge cnt is 4; pause wins over start in RUN.
    pause = 1'b1; start = 1'b1;
    step();
    pause = 1'b0; start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ntests++;
      if ({paused, running, tick, clk_out} !== 4'b1000 || tick_count !== 3'd0) begin
        nfail++;
        $display("FAIL pause_hold: cycle %0d paused/run/tick/clk=%b count=%0d, required 1000 count 0",
                 i, {paused, running, tick, clk_out}, tick_count);
      end
      step();
    end
    r = cyc + 1;
    exp_q.push_back('{r + 6, 1});
    exp_q.push_back('{r + 16, 2});
    start = 1'b1;
    step();
    start = 1'b0;
    ntests++;
    if (running !== 1'b1 || clk_out !== 1'b0) begin
      nfail++;
      $display("FAIL resume: running=%b clk_out=%b, required 1 0", running, clk_out);
    end
    for (int j = 1; j <= 20; j++) begin
      step();
      ntests++;
      if (clk_out !== (((3 + j) % 10) >= 5)) begin
        nfail++;
        $display("FAIL resume_clk_out: edge +%0d got %b, required %b", j, clk_out, ((3 + j) % 10) >= 5);
      end
    end
    pause = 1'b1;
    step();
    pause = 1'b0;
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    ntests++;
    if ({running, paused, clk_out} !== 3'b000 || tick_count !== 3'd2 || exp_q.size() != 0) begin
      nfail++;
      $display("FAIL pause_stop: run/pause/clk=%b count=%0d pending=%0d, required 000 count 2 pending 0",
               {running, paused, clk_out}, tick_count, exp_q.size());
    end
  endtask

  task automatic test_saturation();
    int unsigned s;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_div = 16'd2;
    step();
    cfg_if.cfg_valid = 1'b0;
    s = cyc + 1;
    for (int k = 1; k <= 9; k++) exp_q.push_back('{s + 2 * k, (k > 7) ? 7 : k});
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (3) step();
    ntests++;
    if (running !== 1'b0 || tick_count !== 3'd7 || exp_q.size() != 0) begin
      nfail++;
      $display("FAIL sat_hold: running=%b count=%0d pending=%0d, required 0 count 7 pending 0",
               running, tick_count, exp_q.size());
    end
    start = 1'b1;
    step();
    start = 1'b0;
    ntests++;
    if (running !== 1'b1 || tick_count !== 3'd0) begin
      nfail++;
      $display("FAIL sat_restart: running=%b count=%0d, required 1 count 0", running, tick_count);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_rst_mid_run();
    int unsigned s;
    s = cyc + 1;
    exp_q.push_back('{s + 2, 1});
    exp_q.push_back('{s + 4, 2});
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ntests++;
    if ({tick, clk_out, running, paused, cfg_if.cfg_ready} !== 5'b00001 || tick_count !== 3'd0 ||
        exp_q.size() != 0) begin
      nfail++;
      $display("FAIL rst_mid_run: tick/clk/run/pause/ready=%b count=%0d pending=%0d, required 00001 count 0 pending 0",
               {tick, clk_out, running, paused, cfg_if.cfg_ready}, tick_count, exp_q.size());
    end
    // Reset must also restore the default ratio of 100.
    s = cyc + 1;
    exp_q.push_back('{s + 100, 1});
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (104) step();
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    ntests++;
    if ({running, paused, cfg_if.cfg_ready, clk_out, tick} !== 5'b00100 || tick_count !== 3'd1 ||
        exp_q.size() != 0) begin
      nfail++;
      $display("FAIL stop_start: run/pause/ready/clk/tick=%b count=%0d pending=%0d, required 00100 count 1 pending 0",
               {running, paused, cfg_if.cfg_ready, clk_out, tick}, tick_count, exp_q.size());
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    stop = 1'b1; pause = 1'b1;
    step();
    stop = 1'b0; pause = 1'b0;
    ntests++;
    if ({running, paused, cfg_if.cfg_ready} !== 3'b001) begin
      nfail++;
      $display("FAIL stop_pause: run/pause/ready=%b, required 001", {running, paused, cfg_if.cfg_ready});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_default_ratio();
    test_cfg_same_edge();
    test_clamp();
    test_pause_resume();
    test_saturation();
    test_rst_mid_run();
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
